// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline: forwarding selects, load-use stall, branch flush.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl #(
    parameter int AWIDTH     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_READY = 1,
    parameter int BR_PENALTY = 2,
    parameter int SELW       = 2
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              h_i_ce,
    input  logic              h_i_valid,
    input  logic [AWIDTH-1:0] h_i_rs,
    input  logic [AWIDTH-1:0] h_i_rt,
    input  logic              h_i_use_rs,
    input  logic              h_i_use_rt,
    input  logic [AWIDTH-1:0] h_i_rd,
    input  logic              h_i_reg_write,
    input  logic              h_i_mem_read,
    input  logic              h_i_change_pc,
    output logic              h_o_stall,
    output logic              h_o_flush,
    output logic              h_o_bubble,
    output logic [SELW-1:0]   h_o_fwd_rs,
    output logic [SELW-1:0]   h_o_fwd_rt,
    output logic [31:0]       h_o_stall_cnt,
    output logic [31:0]       h_o_flush_cnt
);

    localparam int FCW = (BR_PENALTY > 2) ? $clog2(BR_PENALTY) : 1;
    localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(BR_PENALTY - 1);

    logic [NSTAGE-1:0] r_vld;
    logic [NSTAGE-1:0] r_rw;
    logic [NSTAGE-1:0] r_mr;
    logic [AWIDTH-1:0] r_rd [NSTAGE];
    logic [FCW-1:0]    r_flush_cnt;

    logic [SELW-1:0]   w_sel_rs;
    logic [SELW-1:0]   w_sel_rt;
    logic              w_lu_rs;
    logic              w_lu_rt;
    logic              w_hazard;
    logic              w_flush_cond;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_sel_rs = '0;
        w_sel_rt = '0;
        w_lu_rs  = 1'b0;
        w_lu_rt  = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (h_i_use_rs && (h_i_rs != '0) && r_vld[k] && r_rw[k] && (r_rd[k] == h_i_rs)) begin
                w_sel_rs = SELW'(k + 1);
                w_lu_rs  = r_mr[k] && (k < LOAD_READY);
            end
            if (h_i_use_rt && (h_i_rt != '0) && r_vld[k] && r_rw[k] && (r_rd[k] == h_i_rt)) begin
                w_sel_rt = SELW'(k + 1);
                w_lu_rt  = r_mr[k] && (k < LOAD_READY);
            end
        end
    end

    assign w_hazard     = h_i_valid && (w_lu_rs || w_lu_rt);
    assign w_flush_cond = h_i_change_pc || (r_flush_cnt != '0);

    assign h_o_flush  = h_i_ce && w_flush_cond;
    assign h_o_stall  = h_i_ce && w_hazard && !w_flush_cond;
    assign h_o_bubble = h_o_stall || h_o_flush;

    // Load data not yet available: select the register file rather than a stale stage.
    assign h_o_fwd_rs = (h_i_valid && !w_hazard) ? w_sel_rs : '0;
    assign h_o_fwd_rt = (h_i_valid && !w_hazard) ? w_sel_rt : '0;

    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            r_vld       <= '0;
            r_rw        <= '0;
            r_mr        <= '0;
            r_flush_cnt <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                r_rd[k] <= '0;
            end
        end else if (h_i_ce) begin
            r_vld[0] <= h_i_valid && !h_o_bubble;
            r_rd[0]  <= h_i_rd;
            r_rw[0]  <= h_i_reg_write;
            r_mr[0]  <= h_i_mem_read;
            for (int k = 1; k < NSTAGE; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_rw[k]  <= r_rw[k-1];
                r_mr[k]  <= r_mr[k-1];
            end
            if (h_i_change_pc) begin
                r_flush_cnt <= FLUSH_RELOAD;
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cyc;

    // Stall and flush already include the ce qualification.
    always_ff @(posedge h_clk) begin
        if (h_rst) begin
            r_stall_cnt <= '0;
            r_flush_cyc <= '0;
        end else begin
            if (h_o_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (h_o_flush && (r_flush_cyc != 32'hFFFF_FFFF)) begin
                r_flush_cyc <= r_flush_cyc + 32'd1;
            end
        end
    end

    assign h_o_stall_cnt = r_stall_cnt;
    assign h_o_flush_cnt = r_flush_cyc;
`else
    assign h_o_stall_cnt = '0;
    assign h_o_flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the pipelined successor of the single-issue MIPS datapath (fetch, decode, execute, memory, writeback). It tracks in-flight destination registers across a parametrised number of post-decode stages and issues per-operand forwarding selects for the decode-stage instruction. It also raises load-use stalls and a multi-cycle branch flush. Self-contained: it sees only register addresses and control bits, never data.

Parameters:
AWIDTH, 5, register address width
NSTAGE, 3, tracked stages after decode (stage 0 = EX, stage NSTAGE-1 = WB)
LOAD_READY, 1, first stage index at which load data is forwardable (ALU results forwardable from stage 0)
BR_PENALTY, 2, cycles the decode instruction is killed after a taken branch/jump
SELW, 2, forward-select width, must satisfy 2^SELW >= NSTAGE+1

Ports:
h_clk  in  1  clock
h_rst  in  1  reset, synchronous, active-high
h_i_ce  in  1  global enable; low = freeze all state
h_i_valid  in  1  decode stage holds a real instruction
h_i_rs, h_i_rt  in  AWIDTH  source register addresses of decode instruction
h_i_use_rs, h_i_use_rt  in  1  operand actually read
h_i_rd  in  AWIDTH  destination of decode instruction
h_i_reg_write  in  1  decode instruction writes rd
h_i_mem_read  in  1  decode instruction is a load
h_i_change_pc  in  1  taken branch/jump resolved in EX this cycle
h_o_stall  out  1  hold PC and IF/ID register
h_o_flush  out  1  kill the decode-stage instruction
h_o_bubble  out  1  inject a bubble into EX (= stall | flush)
h_o_fwd_rs, h_o_fwd_rt  out  SELW  0 = register file, k+1 = forward from stage k
h_o_stall_cnt, h_o_flush_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Clock h_clk and reset h_rst only. Reset is synchronous and active-high.
- Reset: all stage entries invalid, flush counter 0, perf counters 0. Reset takes priority over h_i_change_pc and h_i_ce.
- Tracking pipeline: entry k = {valid, rd, reg_write, mem_read}. Every ce cycle, entry k+1 <= entry k, and entry NSTAGE-1 retires.
- Entry 0 <= decode instruction when h_i_valid & ~h_o_bubble; otherwise a bubble (valid=0).
- Match rule: operand matches entry k iff use=1, addr!=0, entry valid, reg_write=1, and rd==addr. The youngest match (lowest k) wins.
- Forward select: matched k -> k+1; no match -> 0. Combinational from current inputs and state.
- Load-use stall: the youngest match has mem_read=1 and k < LOAD_READY. Then h_o_stall=1 and fwd outputs read 0.
  - Stall lasts exactly LOAD_READY-k cycles, because the load ages while the bubble is inserted.
  - Defaults: back-to-back load-use stalls 1 cycle.
- Flush: h_i_change_pc=1 in cycle t loads the flush counter with BR_PENALTY-1 and asserts h_o_flush in cycle t.
  - h_o_flush stays high while the counter is non-zero; the counter decrements each ce cycle.
  - Defaults: flush in t and t+1.
  - A new change_pc during an active flush reloads the counter.
- Flush beats stall: when both conditions hold, h_o_stall=0, h_o_flush=1.
- h_i_valid=0: no stall; fwd outputs 0.
- h_i_ce=0: state holds; h_o_stall, h_o_flush, h_o_bubble are 0; fwd outputs still reflect state.
- Latency: all outputs combinational in the same cycle; state updates at the next h_clk edge.
- Register 0 never hazards or forwards.

Optional Feature:
HAZARD_PERF_EN
- Defined: h_o_stall_cnt increments on every ce cycle with h_o_stall=1, and h_o_flush_cnt on every ce cycle with h_o_flush=1. Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter registers are synthesised.

Test Plan:
1. ALU chain: add r3 (cycle 0), then sub using rs=r3 (cycle 1) -> cycle 1: fwd_rs=1, stall=0. Same consumer two cycles later -> fwd_rs=2. Three cycles later -> fwd_rs=3.
2. Load-use: lw r5 (cycle 0), then add rt=r5 (cycle 1) -> cycle 1: stall=1, bubble=1, fwd_rt=0. Cycle 2: stall=0, fwd_rt=2 (from MEM).
3. Register 0 and unused operand: producer writes r0 and consumer reads r0 -> fwd=0, stall=0. Producer writes r7, consumer rt=r7 with use_rt=0 -> fwd_rt=0.
4. Branch: change_pc at cycle 10 -> flush=1 in cycles 10 and 11, 0 in cycle 12. Entry 0 invalid after edges 10 and 11. A second change_pc at cycle 11 extends flush through cycle 12.
5. Simultaneous: load-use condition plus change_pc in the same cycle -> stall=0, flush=1, bubble=1.
6. Reset mid-flush and ce gating:
   - h_rst at cycle 11 of scenario 4 -> from cycle 12: flush=0, all fwd=0, counters 0.
   - h_i_ce=0 for 3 cycles during a pending load-use -> state unchanged and stall=0 throughout; the stall reappears when ce returns to 1.
   - With HAZARD_PERF_EN, after scenarios 2 and 4 -> stall_cnt=1, flush_cnt=2.
